// File: rtl/keypad_pkg.sv
// keypad_pkg: scan FSM state type and the 16-entry key decode table
// shared by keypad_scan and keypad_entry.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } kstate_t;

    // indexed by {row, col}; row 0 / col 0 are row[0] / col[0]
    localparam logic [3:0] KEY_TABLE [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic logic one_low(input logic [3:0] v);
        logic [3:0] n;
        n = ~v;
        return (n != 4'h0) && ((n & (n - 4'h1)) == 4'h0);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (!v[1])
            idx = 2'd1;
        else if (!v[2])
            idx = 2'd2;
        else if (!v[3])
            idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] key_decode(
        input logic [1:0] r,
        input logic [1:0] c
    );
        return KEY_TABLE[{r, c}];
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: column scanner, press/release debouncer and key decoder.
// Emits a one-cycle key_evt with the decoded digit per debounced press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] digit,
    output logic       key_evt
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    kstate_t       state;
    kstate_t       state_n;
    logic [DW-1:0] dwell;
    logic [3:0]    col_n;
    logic [3:0]    ref_row;
    logic [3:0]    ref_row_n;
    logic [3:0]    dcnt;
    logic [3:0]    dcnt_n;
    logic          samp;
    logic          evt;

    assign samp = (dwell == LAST);

    // free-running dwell timer; samp marks the last clock of each dwell
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dwell <= '0;
        else if (samp)
            dwell <= '0;
        else
            dwell <= dwell + DW'(1);
    end

    // FSM state, frozen column, debounce count and event/digit outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_SCAN;
            col     <= 4'b1110;
            dcnt    <= '0;
            ref_row <= 4'hF;
            digit   <= '0;
            key_evt <= 1'b0;
        end else begin
            state   <= state_n;
            col     <= col_n;
            dcnt    <= dcnt_n;
            ref_row <= ref_row_n;
            key_evt <= evt;
            if (evt)
                digit <= key_decode(low_index(ref_row), low_index(col));
        end
    end

    // next-state logic, evaluated only on sample clocks
    always_comb begin
        state_n   = state;
        col_n     = col;
        dcnt_n    = dcnt;
        ref_row_n = ref_row;
        evt       = 1'b0;
        if (samp) begin
            unique case (state)
                S_SCAN: begin
                    if (one_low(row)) begin
                        state_n   = S_DEBOUNCE;
                        ref_row_n = row;
                        dcnt_n    = '0;
                    end else begin
                        col_n = {col[2:0], col[3]};
                    end
                end
                S_DEBOUNCE: begin
                    if (row != ref_row) begin
                        state_n = S_SCAN;
                    end else if (dcnt == DB_LAST) begin
                        state_n = S_HELD;
                        evt     = 1'b1;
                    end else begin
                        dcnt_n = dcnt + 4'd1;
                    end
                end
                S_HELD: begin
                    if (row == 4'hF) begin
                        state_n = S_RELEASE;
                        dcnt_n  = '0;
                    end
                end
                S_RELEASE: begin
                    if (row != 4'hF)
                        state_n = S_HELD;
                    else if (dcnt == DB_LAST)
                        state_n = S_SCAN;
                    else
                        dcnt_n = dcnt + 4'd1;
                end
                default: state_n = S_SCAN;
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: hex digit entry buffer with backspace, commit and
// valid/ready output. Debug ports exist when KEYPAD_ENTRY_DEBUG_EN is set.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 row,
    output logic [3:0]                 col,
    input  logic                       bksp,
    input  logic                       enter,
    output logic [DIGITS*4-1:0]        entry,
    output logic [$clog2(DIGITS+1)-1:0] count,
    output logic [DIGITS*4-1:0]        out,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef KEYPAD_ENTRY_DEBUG_EN
    ,
    output logic [3:0]                 dbg_value,
    output logic                       dbg_trig
`endif
);

    localparam int W  = DIGITS * 4;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic [3:0] digit;
    logic       key_evt;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .row     (row),
        .col     (col),
        .digit   (digit),
        .key_evt (key_evt)
    );

`ifdef KEYPAD_ENTRY_DEBUG_EN
    assign dbg_value = digit;
    assign dbg_trig  = key_evt;
`endif

    // buffer edits (bksp > enter > key) and the output handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry     <= '0;
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (bksp) begin
                if (count != '0) begin
                    entry <= entry >> 4;
                    count <= count - CW'(1);
                end
            end else if (enter) begin
                if (count != '0 && !out_valid) begin
                    out       <= entry;
                    out_valid <= 1'b1;
                    entry     <= '0;
                    count     <= '0;
                end
            end else if (key_evt && count != FULL) begin
                entry <= (entry << 4) | W'(digit);
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad press model driven from col, queue-based
// reference of the digit buffer, directed cases plus random operations.
`timescale 1ns/1ps
module tb_keypad_entry;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 4;
    localparam int CW       = $clog2(DIGITS + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    row;
    logic [3:0]    col;
    logic          bksp = 1'b0;
    logic          enter = 1'b0;
    logic          out_ready = 1'b0;
    logic [15:0]   entry;
    logic [15:0]   out;
    logic [CW-1:0] count;
    logic          out_valid;
`ifdef KEYPAD_ENTRY_DEBUG_EN
    logic [3:0]    dbg_value;
    logic          dbg_trig;
`endif

    always #5 clk = ~clk;

    keypad_entry #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .bksp      (bksp),
        .enter     (enter),
        .entry     (entry),
        .count     (count),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef KEYPAD_ENTRY_DEBUG_EN
        ,
        .dbg_value (dbg_value),
        .dbg_trig  (dbg_trig)
`endif
    );

    // physical keypad: a closed key pulls its row low while its column is driven
    logic       key_on = 1'b0;
    logic [1:0] kr = 2'd0;
    logic [1:0] kc = 2'd0;
    always_comb row = (key_on && !col[kc]) ? ~(4'b0001 << kr) : 4'hF;

    logic [3:0] kmap [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    // reference: digits held oldest-first, committed value and its flag
    logic [3:0]  q [$];
    logic [15:0] m_out = '0;
    logic        m_valid = 1'b0;

    int   errors = 0;
    int   checks = 0;
    logic chk_buf = 1'b0;
    logic chk_out = 1'b0;
    int   ncyc = 0;

    function automatic logic [15:0] m_entry();
        logic [15:0] v;
        v = '0;
        foreach (q[i]) v = (v << 4) | 16'(q[i]);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // clocks since reset release; a row sample happens when it hits n*SCAN_DIV
    always @(posedge clk or negedge reset)
        if (!reset) ncyc <= 0;
        else ncyc <= ncyc + 1;

    // per-cycle comparison against the reference
    always @(negedge clk) begin
        if (reset) begin
            check("col_onehot",
                  (col == 4'hE || col == 4'hD || col == 4'hB || col == 4'h7), 1);
            if (chk_buf) begin
                check("entry", entry, m_entry());
                check("count", count, q.size());
            end
            if (chk_out) begin
                check("out", out, m_out);
                check("out_valid", out_valid, m_valid);
            end
        end
    end

`ifdef KEYPAD_ENTRY_DEBUG_EN
    always @(negedge clk)
        if (reset && dbg_trig) check("dbg_value", dbg_value, kmap[kr][kc]);
`endif

    task automatic do_reset();
        chk_buf = 1'b0; chk_out = 1'b0;
        key_on = 1'b0; bksp = 1'b0; enter = 1'b0; out_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        q.delete(); m_out = '0; m_valid = 1'b0;
        @(posedge clk); #1;
        chk_buf = 1'b1; chk_out = 1'b1;
    endtask

    task automatic cyc(input logic b, input logic e, input logic r);
        logic old;
        logic [3:0] tmp;
        bksp = b; enter = e; out_ready = r;
        @(posedge clk);
        old = m_valid;
        if (b) begin
            if (q.size() > 0) tmp = q.pop_back();
        end else if (e) begin
            if (q.size() > 0 && !old) begin
                m_out = m_entry(); m_valid = 1'b1; q.delete();
            end
        end
        if (old && r) m_valid = 1'b0;
        #1;
        bksp = 1'b0; enter = 1'b0; out_ready = 1'b0;
    endtask

    task automatic press(input int r, input int c,
                         input int hold = 14, input int rel = 8);
        chk_buf = 1'b0;
        kr = r[1:0]; kc = c[1:0]; key_on = 1'b1;
        repeat (hold * SCAN_DIV) @(posedge clk);
        #1 key_on = 1'b0;
        repeat (rel * SCAN_DIV) @(posedge clk);
        #1;
        if (q.size() < DIGITS) q.push_back(kmap[r][c]);
        chk_buf = 1'b1;
    endtask

    task automatic wait_sample();
        do begin
            @(posedge clk); #1;
        end while (ncyc % SCAN_DIV != 0);
    endtask

    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (col[c] !== 1'b0 && n < 8 * SCAN_DIV) begin
            @(posedge clk); #1; n++;
        end
        check("wait_col", col[c], 0);
    endtask

    initial begin
        int op;
        do_reset();
        check("rst_entry", entry, 0);
        check("rst_count", count, 0);
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_col", col, 4'hE);

        press(1, 2); press(3, 1);
        check("two_entry", entry, 16'h006F);
        check("two_count", count, 2);

        do_reset();
        press(0, 0); press(0, 1); press(0, 2); press(1, 0); press(1, 1);
        check("full_entry", entry, 16'h1234);
        check("full_count", count, 4);
        cyc(1, 0, 0);
        check("bksp_entry", entry, 16'h0123);
        check("bksp_count", count, 3);

        do_reset();
        press(0, 3); press(1, 3);
        check("ab_entry", entry, 16'h00AB);
        cyc(0, 1, 0);
        check("commit_out", out, 16'h00AB);
        check("commit_valid", out_valid, 1);
        check("commit_entry", entry, 0);
        repeat (10) cyc(0, 0, 0);
        check("stall_valid", out_valid, 1);
        press(2, 0);
        cyc(0, 1, 0);
        check("enter2_out", out, 16'h00AB);
        check("enter2_entry", entry, 16'h0007);
        cyc(0, 0, 1);
        check("ack_valid", out_valid, 0);

        do_reset();
        press(0, 0); press(0, 1);
        cyc(1, 1, 0);
        check("prio_count", count, 1);
        check("prio_entry", entry, 16'h0001);
        check("prio_valid", out_valid, 0);

        do_reset();
        chk_buf = 1'b0;
        kr = 2'd2; kc = 2'd2;
        wait_col(2);
        key_on = 1'b1; wait_sample();
        key_on = 1'b0; wait_sample();
        check("bounce_none", count, 0);
        key_on = 1'b1;
        repeat (14 * SCAN_DIV) @(posedge clk);
        #1 key_on = 1'b0;
        repeat (8 * SCAN_DIV) @(posedge clk);
        #1;
        q.push_back(4'h9); chk_buf = 1'b1;
        check("bounce_entry", entry, 16'h0009);
        check("bounce_count", count, 1);

        do_reset();
        press(0, 2); cyc(0, 1, 0); press(1, 1);
        check("pre_rst_valid", out_valid, 1);
        chk_buf = 1'b0;
        kr = 2'd3; kc = 2'd3;
        wait_col(3);
        key_on = 1'b1; wait_sample(); wait_sample();
        #3 reset = 1'b0; chk_out = 1'b0;
        #1;
        check("mid_entry", entry, 0);
        check("mid_count", count, 0);
        check("mid_out", out, 0);
        check("mid_valid", out_valid, 0);
        check("mid_col", col, 4'hE);
        q.delete(); m_out = '0; m_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        chk_out = 1'b1;
        repeat (14 * SCAN_DIV) @(posedge clk);
        #1 key_on = 1'b0;
        repeat (8 * SCAN_DIV) @(posedge clk);
        #1;
        q.push_back(4'hD); chk_buf = 1'b1;
        check("rekey_entry", entry, 16'h000D);
        check("rekey_count", count, 1);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4);
            if (op < 2)
                press($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(10, 16), $urandom_range(8, 10));
            else
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of hex digits in the entry buffer (range 1..16).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, meaning clocks per column dwell (at least 4).
REQ-003 SHALL have parameter DEBOUNCE, default 4, meaning consecutive matching scans required for press and for release (range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port row, input, 4 bits: keypad rows, active-low, externally pulled up.
REQ-007 SHALL have port col, output, 4 bits: keypad column drive, one-hot active-low.
REQ-008 SHALL have port bksp, input, 1 bit: single-cycle pulse that deletes the last digit.
REQ-009 SHALL have port enter, input, 1 bit: single-cycle pulse that commits the buffer.
REQ-010 SHALL have port entry, output, DIGITS*4 bits: live buffer contents, newest digit in bits [3:0].
REQ-011 SHALL have port count, output, $clog2(DIGITS+1) bits: number of digits held.
REQ-012 SHALL have port out, output, DIGITS*4 bits: committed value.
REQ-013 SHALL have port out_valid, output, 1 bit: committed value available.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts out.

Function
REQ-015 SHALL advance col through 4'b1110, 1101, 1011, 0111 and back to 1110, holding each step SCAN_DIV clocks, while the FSM is in SCAN.
REQ-016 SHALL sample row on the last dwell clock of each column.
REQ-017 SHALL implement states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-018 SHALL move SCAN->DEBOUNCE when the sample has exactly one row low; col is frozen from that point.
REQ-019 SHALL move DEBOUNCE->HELD after DEBOUNCE consecutive identical samples, and DEBOUNCE->SCAN on any differing sample.
REQ-020 SHALL emit exactly one key event on the DEBOUNCE->HELD transition.
REQ-021 SHALL move HELD->RELEASE on the first sample with row==4'hF.
REQ-022 SHALL return RELEASE->SCAN after DEBOUNCE consecutive all-high samples, and return RELEASE->HELD on any low sample; no second event is emitted.
REQ-023 SHALL ignore multi-key samples (more than one row low) in SCAN.
REQ-024 SHALL decode row r (0 = row[0]) and column c (0 = col[0]) as: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = 0 F E D.
REQ-025 SHALL, on a key event with count<DIGITS, set entry to {entry[DIGITS*4-5:0], digit} and increment count, one cycle after the event.
REQ-026 SHALL discard a key event when count==DIGITS, leaving entry and count unchanged.
REQ-027 SHALL, on bksp with count>0, shift entry right 4 bits (zero fill) and decrement count; bksp with count==0 SHALL be ignored.
REQ-028 SHALL, on enter with count>0 and out_valid low, load out<=entry, set out_valid, and clear entry and count, all in the same edge.
REQ-029 SHALL ignore enter when count==0 or out_valid is high.
REQ-030 SHALL hold out_valid and keep out stable until a cycle with out_valid&&out_ready, and clear out_valid on that edge.
REQ-031 SHALL continue accepting digits and bksp while out_valid is high.
REQ-032 SHALL give simultaneous events the priority bksp > enter > key event; the lower-priority events in that cycle are dropped.

Reset
REQ-033 SHALL, while reset is low, asynchronously force: state SCAN, col=4'b1110, dwell and debounce counters 0, entry 0, count 0, out 0, out_valid 0.
REQ-034 SHALL abandon any partial press on mid-operation reset; a key still held after release of reset SHALL be debounced afresh and produce one event.

Configuration
REQ-035 SHALL add output ports dbg_value (4 bits, last decoded digit, reset 0) and dbg_trig (1 bit, high for the key-event cycle, reset 0) when KEYPAD_ENTRY_DEBUG_EN is defined.
REQ-036 SHALL omit both debug ports and their logic when KEYPAD_ENTRY_DEBUG_EN is undefined; all other behaviour SHALL be identical.

Structure
REQ-037 SHALL place the FSM state enum and the 16-entry decode table in shared package keypad_pkg.
REQ-038 SHALL implement the scan/debounce/decode logic as sub-module keypad_scan, with outputs digit and a key-event strobe; the buffer and handshake SHALL stay in keypad_entry.

Verification
REQ-039 SHALL cover: with DIGITS=4, press r1c2 then r3c1 -> entry=16'h006F, count=2, exactly two events.
REQ-040 SHALL cover: a press bouncing for 2 samples and then stable for DEBOUNCE=4 samples -> one event, digit correct.
REQ-041 SHALL cover: keys 1,2,3,4,5 -> entry=16'h1234, count=4 (5 discarded); then bksp -> entry=16'h0123, count=3.
REQ-042 SHALL cover: entry 16'h00AB, enter with out_ready=0 -> out=16'h00AB, out_valid held 10 cycles, entry=0; a second enter is ignored; out_ready=1 -> out_valid clears next edge.
REQ-043 SHALL cover: bksp and enter in the same cycle with count=2 -> count=1, out_valid stays 0.
REQ-044 SHALL cover: reset asserted during DEBOUNCE -> all outputs at reset values immediately, and col=4'b1110.
